eye_chart_display_ctrl: RTL
===========================

# eye_chart_display_ctrl

Test-sequencing controller for the eye-chart VGA design. It debounces the three board pushbuttons and runs the test state machine, which selects the letter size (level 1 = smallest, 8 = biggest) fed to the VGA letter generator. It also counts correct readings and time-multiplexes size and score onto a shared 4-digit, active-low seven-segment display. It replaces direct button-to-size decoding: all size selection goes through this block.

## Interface

- DEBOUNCE_CYC, 500000: cycles a synchronized button level must be stable before it is accepted (10 ms at 50 MHz).
- SCAN_DIV, 50000: cycles each digit stays enabled (1 kHz digit rate at 50 MHz); minimum 2.
- clk  in  1  system clock; the only clock.
- reset  in  1  reset is synchronous and active-high.
- btn_up  in  1  raw pushbutton, active-low (0 = pressed), asynchronous: increase size.
- btn_down  in  1  raw pushbutton, active-low, asynchronous: decrease size.
- btn_ok  in  1  raw pushbutton, active-low, asynchronous: start / correct reading / restart.
- level_out  out  3  current size code to the VGA letter generator; value 0..7 means size 1..8.
- test_done  out  1  high while in DONE.
- seg_out  out  7  segments {g,f,e,d,c,b,a}, active-low (0 = "1000000", blank = "1111111", dash = "0111111", 'd' = "0100001").
- digit_en  out  4  digit enables, active-low, one-hot-cold; bit 0 is the rightmost digit.

## Operation

- Button path, per button:
  - 2-flop synchronizer, reset to 1.
  - Stability counter: counts while the synchronized value differs from the debounced value and clears otherwise. When it reaches DEBOUNCE_CYC, the debounced value takes the synchronized value and the counter clears.
  - A 1→0 transition of the debounced value produces a one-cycle press pulse. Releases produce nothing.
  - Holding a button gives exactly one pulse; there is no auto-repeat.
- Pulse priority when several pulses occur in the same cycle: ok > down > up. Lower-priority pulses in that cycle are discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE: level = 7. Up and down are ignored. Ok → RUN, clearing the score to 00.
  - RUN, up: level+1, saturating at 7.
  - RUN, down: level−1, saturating at 0.
  - RUN, ok: score+1. If level > 0, level−1 and stay in RUN; if level = 0, → DONE with level held at 0.
  - DONE: up and down are ignored. Ok → IDLE with level = 7 and the score held until the next start.
- Score: two BCD registers (tens, units), 00..99. Increments saturate at 99; no binary-to-BCD division.
- Display scan:
  - The prescaler counts 0..SCAN_DIV−1. On the terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
  - Digit content:
    - Digit 0: score units.
    - Digit 1: score tens; blank if tens = 0.
    - Digit 2: blank in IDLE, dash in RUN, 'd' in DONE.
    - Digit 3: level_out+1 (1..8).
  - In IDLE, digits 0 and 1 show the held score (00 after reset).
- Reset (any cycle, including mid-debounce or mid-scan):
  - state IDLE, level_out = 7, score 00, test_done 0;
  - prescaler 0, index 0;
  - all debounced values released, stability counters 0;
  - seg_out = "1111111", digit_en = "1111".

## Timing

- A raw press stable from cycle t: the synchronized value changes at t+2 and the press pulse is high in cycle t+2+DEBOUNCE_CYC.
- The FSM, level_out, score and test_done update on the clock edge that ends the pulse cycle. Example: with DEBOUNCE_CYC = 4 and the raw input low from cycle 0, the pulse is high in cycle 6 and level_out is new from cycle 7.
- Bounces shorter than DEBOUNCE_CYC cycles produce no pulse and no state change.
- seg_out and digit_en are registered, with 1-cycle latency from index/data: the first cycle after reset deasserts enables digit 0.
- The index changes every SCAN_DIV cycles; seg_out and digit_en change on the same edge, so no cycle shows the old segments on the new digit.
- A level or score change reaches seg_out no later than 1 cycle after the next scan of that digit.

## Test plan

Benches use DEBOUNCE_CYC = 4 and SCAN_DIV = 3.

- Reset, then idle for 20 cycles → level_out = 7, test_done = 0, digit_en cycles 1110→1101→1011→0111 every 3 cycles, digit 3 shows "0000000" (8).
- Press ok (held 10 cycles), then press down three times → state RUN, level_out = 4, digit 2 shows dash, score 00.
- In RUN, 2-cycle low glitches on btn_up → no pulse, level_out unchanged. In RUN, ok and up pressed on the same cycle → only ok acts: score 01, level−1.
- From level 7 in RUN, ok pressed 8 times → score 08, level_out = 0 after the 7th press, DONE after the 8th, test_done = 1, digit 2 shows "0100001". Up at level 7 and down at level 0 saturate.
- Force 99 correct readings via up/ok cycling → score stays 99 on further ok; digit 1 shows "0010000", digit 0 shows "0010000".
- Assert reset in RUN mid-debounce (btn_down low for 2 cycles) → next cycle IDLE, level_out = 7, score 00, digit_en = 1111, no pulse after reset release until a fresh 4-cycle stable press.

Source files
------------

// File: rtl/eye_chart_display_ctrl.sv
// eye_chart_display_ctrl
// Test sequencer for the eye-chart VGA design. It debounces the three board
// pushbuttons, runs the IDLE/RUN/DONE test state machine that picks the letter
// size, keeps a BCD score of correct readings, and scans size and score onto a
// shared 4-digit active-low seven-segment display.
//
// Ports
//   clk        system clock (only clock)
//   reset      synchronous, active-high
//   btn_up     raw pushbutton, active-low, asynchronous: increase size
//   btn_down   raw pushbutton, active-low, asynchronous: decrease size
//   btn_ok     raw pushbutton, active-low, asynchronous: start / correct / restart
//   level_out  size code 0..7 (size 1..8) to the letter generator
//   test_done  high while in DONE
//   seg_out    segments {g,f,e,d,c,b,a}, active-low, registered
//   digit_en   digit enables, active-low one-hot-cold, bit 0 = rightmost, registered
module eye_chart_display_ctrl #(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int SCAN_DIV     = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_ok,
    output logic [2:0] level_out,
    output logic       test_done,
    output logic [6:0] seg_out,
    output logic [3:0] digit_en
);

    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_D     = 7'b0100001;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // BCD increment of {tens,units}, saturating at 99.
    function automatic logic [7:0] bcd_inc_sat(input logic [3:0] tens, input logic [3:0] units);
        if (tens == 4'd9 && units == 4'd9) return {tens, units};
        else if (units == 4'd9)            return {tens + 4'd1, 4'd0};
        else                               return {tens, units + 4'd1};
    endfunction

    // ---- stage p0/p1: button synchronizers, then debounce ----
    logic [2:0]      btn_raw, sync_p0, sync_p1, deb, deb_d, press;
    logic [DB_W-1:0] db_cnt [3];

    assign btn_raw = {btn_ok, btn_down, btn_up};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '1;
            sync_p1 <= '1;
            deb     <= '1;
            deb_d   <= '1;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
            deb_d   <= deb;
            for (int i = 0; i < 3; i++) begin
                if (sync_p1[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    // DEBOUNCE_CYC cycles of disagreement: accept the new level
                    deb[i]    <= sync_p1[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Press = debounced falling edge; releases are ignored.
    assign press = deb_d & ~deb;

    // ---- test state machine and score ----
    logic ok_p, dn_p, up_p;
    assign ok_p = press[2];
    assign dn_p = press[1] & ~press[2];
    assign up_p = press[0] & ~press[1] & ~press[2];

    state_t     state, state_nx;
    logic [2:0] level, level_nx;
    logic [3:0] sc_t, sc_u, sc_t_nx, sc_u_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            level <= 3'd7;
            sc_t  <= 4'd0;
            sc_u  <= 4'd0;
        end else begin
            state <= state_nx;
            level <= level_nx;
            sc_t  <= sc_t_nx;
            sc_u  <= sc_u_nx;
        end
    end

    always_comb begin
        state_nx = state;
        level_nx = level;
        sc_t_nx  = sc_t;
        sc_u_nx  = sc_u;
        case (state)
            IDLE: begin
                if (ok_p) begin
                    state_nx = RUN;
                    sc_t_nx  = 4'd0;
                    sc_u_nx  = 4'd0;
                end
            end
            RUN: begin
                if (ok_p) begin
                    {sc_t_nx, sc_u_nx} = bcd_inc_sat(sc_t, sc_u);
                    if (level != 3'd0) level_nx = level - 3'd1;
                    else               state_nx = DONE;
                end else if (dn_p) begin
                    if (level != 3'd0) level_nx = level - 3'd1;
                end else if (up_p) begin
                    if (level != 3'd7) level_nx = level + 3'd1;
                end
            end
            DONE: begin
                if (ok_p) begin
                    state_nx = IDLE;
                    level_nx = 3'd7;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign level_out = level;
    assign test_done = (state == DONE);

    // ---- display scan: index and segment data registered together ----
    logic [SC_W-1:0] presc;
    logic [1:0]      idx;
    logic [6:0]      seg_nx;

    always_comb begin
        seg_nx = SEG_BLANK;
        case (idx)
            2'd0: seg_nx = seg_digit(sc_u);
            2'd1: seg_nx = (sc_t == 4'd0) ? SEG_BLANK : seg_digit(sc_t);
            2'd2: begin
                if (state == RUN)       seg_nx = SEG_DASH;
                else if (state == DONE) seg_nx = SEG_D;
                else                    seg_nx = SEG_BLANK;
            end
            default: seg_nx = seg_digit({1'b0, level} + 4'd1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc    <= '0;
            idx      <= 2'd0;
            seg_out  <= SEG_BLANK;
            digit_en <= 4'b1111;
        end else begin
            seg_out  <= seg_nx;
            digit_en <= ~(4'b0001 << idx);
            if (presc == SC_LAST) begin
                presc <= '0;
                idx   <= idx + 2'd1;
            end else begin
                presc <= presc + SC_W'(1);
            end
        end
    end

endmodule
